sram_bist_ctrl: RTL and testbench
=================================

# sram_bist_ctrl

March C- built-in self-test controller for the 4-location × 4-bit SRAM macro. It sits directly upstream of the SRAM and owns its `dataIn`/`Addr`/`CS`/`WE`/`RD` pins while a test runs. It checks every read against the expected background and reports pass/fail to the system controller.

## Interface
Parameters:
- `ADDR_W`, 2: SRAM address width; N = 2^ADDR_W locations.
- `DATA_W`, 4: SRAM word width.
- `READ_LAT`, 1: cycles from the `sram_rd` edge to valid `sram_q`; legal values 1..3.

Ports:
- `Clk`  in  1: sole clock; all logic on posedge.
- `Rst`  in  1: reset, synchronous, active-high.
- `start`  in  1: run request; sampled in IDLE or DONE.
- `busy`  out  1: test in progress.
- `done`  out  1: test finished; held until the next start or `Rst`.
- `pass`  out  1: valid while `done`=1; 1 means no mismatch.
- `sram_din`  out  DATA_W: drives SRAM `dataIn`.
- `sram_addr`  out  ADDR_W: drives SRAM `Addr`.
- `sram_cs`, `sram_we`, `sram_rd`  out  1 each: drive SRAM `CS`/`WE`/`RD`.
- `sram_q`  in  DATA_W: SRAM read data.
- `fail_addr`  out  ADDR_W: address of the first mismatch.
- `fail_elem`  out  3: March element index (0..5) of the first mismatch.
- `fail_data`  out  DATA_W: data read at the first mismatch.
- `fail_exp`  out  DATA_W: data expected at the first mismatch.

## Operation
- Backgrounds: B0 = all zeros, B1 = all ones.
- March elements, in order:
  - E0 ⇑(w B0)
  - E1 ⇑(r B0, w B1)
  - E2 ⇑(r B1, w B0)
  - E3 ⇓(r B0, w B1)
  - E4 ⇓(r B1, w B0)
  - E5 ⇑(r B0)
- Address order: ⇑ runs 0→N-1; ⇓ runs N-1→0.
- FSM states: IDLE, WR, RD, WAIT, DONE.
  - IDLE/DONE + `start` → E0 WR at address 0; clears `done`, `pass`, and the fail registers.
  - WR: one write cycle. `sram_cs`=1, `sram_we`=1, `sram_rd`=0, `sram_din` = background. Then advance to the next address, or to the next element's first op, or to DONE after the last element.
  - RD: one read cycle. `sram_cs`=1, `sram_rd`=1, `sram_we`=0. Then WAIT.
  - WAIT: READ_LAT-1 idle cycles. The compare occurs in the cycle where `sram_q` is valid (READ_LAT cycles after RD). That same cycle issues the element's write (E1–E4) or advances the address (E5).
- All SRAM-side outputs are low in IDLE, WAIT-idle, and DONE. `WE` and `RD` are never high together.
- Mismatch means `sram_q` ≠ expected background. The first mismatch latches `fail_*` and clears the internal pass flag.
- `start` while busy is ignored.
- `Rst` at any cycle → IDLE on the next edge. An aborted run leaves no partial `done`.

## Timing
- Reset values: `busy`=0, `done`=0, `pass`=0, all `sram_*` outputs 0, all `fail_*` outputs 0.
- All outputs are registered.
- `start` high at edge k → `busy`=1 and the first write is driven after edge k.
- Run length, `busy` high: N + 5·N·(1+READ_LAT) cycles.
  - 44 cycles for N=4, READ_LAT=1.
  - 64 cycles for N=4, READ_LAT=2.
- `done`=1 and `pass` are valid on the same edge that `busy` falls; both hold until the next `start` or `Rst`.
- `start` held high continuously → a new run begins the cycle after DONE is entered. `done` pulses for one cycle.
- Address wrap: the ⇑ terminal count is N-1 and the ⇓ terminal count is 0. The counter never wraps within an element.

## Configuration
- `SRAM_BIST_DIAG_EN` defined:
  - The first mismatch aborts the run and enters DONE with `pass`=0 in the cycle after the compare.
  - `fail_addr`, `fail_elem`, `fail_data`, and `fail_exp` hold the captured values.
- `SRAM_BIST_DIAG_EN` undefined:
  - The run always completes the full length, and `pass` is the AND of all compares.
  - `fail_*` ports are tied to 0; the capture registers are not built.

## Structure
- Shared package `sram_bist_pkg` holds:
  - the FSM state enum;
  - the element-index type;
  - the per-element descriptor constant (direction, read background, has-read, has-write, write background);
  - the B0/B1 background functions of DATA_W.
- Sub-module `sram_bist_addr_gen`:
  - up/down address counter with load-start, increment/decrement, and a last-address flag.
  - The FSM instantiates it once.

## Test plan
- Fault-free SRAM model, READ_LAT=1, `start` pulsed → `busy` high for exactly 44 cycles, then `done`=1 and `pass`=1. Pin protocol is checked every cycle: never `WE`&`RD`, `CS`=1 on every op.
- Bit 0 of address 2 stuck-at-1, DIAG_EN defined → fail at E1:
  - `fail_addr`=2, `fail_elem`=1, `fail_data`=4'b0001, `fail_exp`=4'b0000.
  - `done` within 1 cycle of the compare, `pass`=0.
- Same fault, DIAG_EN undefined → full 44-cycle run, `pass`=0, `fail_*`=0.
- Address 3 bit 3 stuck-at-0 → first fail at E2: `fail_addr`=3, `fail_data`=4'b0111, `fail_exp`=4'b1111.
- `Rst` asserted at cycle 10 of a run → next cycle all `sram_*`=0, `busy`=0, `done`=0. A new `start` then completes in 44 cycles with `pass`=1.
- READ_LAT=2, `start` held high throughout → 64-cycle runs back-to-back, `done` pulses 1 cycle each run, and `start` is ignored while `busy`.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types for the March C- SRAM BIST: FSM states, element index, element descriptors, backgrounds.
// Pure declarations; no logic or timing of its own.
package sram_bist_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR,
    RD,
    WAIT,
    DONE
  } bist_state_t;

  typedef logic [2:0] elem_idx_t;

  localparam elem_idx_t LAST_ELEM = 3'd5;

  typedef struct packed {
    logic down;    // address order: 1 = N-1 -> 0
    logic has_rd;
    logic rd_bg;   // expected background: 0 = B0, 1 = B1
    logic has_wr;
    logic wr_bg;
  } elem_desc_t;

  // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 down(r0,w1) E4 down(r1,w0) E5 up(r0)
  localparam elem_desc_t [5:0] MARCH_C = {
    elem_desc_t'{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b0, wr_bg: 1'b0},
    elem_desc_t'{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    elem_desc_t'{down: 1'b1, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    elem_desc_t'{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b1, has_wr: 1'b1, wr_bg: 1'b0},
    elem_desc_t'{down: 1'b0, has_rd: 1'b1, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b1},
    elem_desc_t'{down: 1'b0, has_rd: 1'b0, rd_bg: 1'b0, has_wr: 1'b1, wr_bg: 1'b0}
  };

  localparam int MAX_DATA_W = 64;

  function automatic logic [MAX_DATA_W-1:0] bg_b0(input int unsigned width);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) w[i] = 1'b0;
    end
    return w;
  endfunction

  function automatic logic [MAX_DATA_W-1:0] bg_b1(input int unsigned width);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int unsigned i = 0; i < MAX_DATA_W; i++) begin
      if (i < width) w[i] = 1'b1;
    end
    return w;
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down March address counter with load-start, step and last-address flag.
// Registered count, addr_nxt is the combinational next value; no backpressure.
module sram_bist_addr_gen
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W = 2
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              load,
  input  logic              down,
  input  logic              step,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] addr_nxt,
  output logic              last
);

  logic dir_down;

  // load wins over step; the direction is captured on load and held for the element
  always_comb begin
    addr_nxt = addr;
    if (load) begin
      addr_nxt = down ? '1 : '0;
    end else if (step) begin
      addr_nxt = dir_down ? addr - ADDR_W'(1) : addr + ADDR_W'(1);
    end
  end

  assign last = dir_down ? (addr == '0) : (addr == '1);

  always_ff @(posedge Clk) begin
    if (Rst) begin
      addr     <= '0;
      dir_down <= 1'b0;
    end else begin
      addr <= addr_nxt;
      if (load) dir_down <= down;
    end
  end

endmodule

// File: rtl/sram_bist_ctrl.sv
// March C- BIST controller driving the SRAM pins; SRAM_BIST_DIAG_EN adds fail capture and abort-on-first-fail.
// Busy for N+5N(1+READ_LAT) cycles, all outputs registered; no backpressure, start ignored while busy.
module sram_bist_ctrl
  import sram_bist_pkg::*;
#(
  parameter int ADDR_W   = 2,
  parameter int DATA_W   = 4,
  parameter int READ_LAT = 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [DATA_W-1:0] sram_din,
  output logic [ADDR_W-1:0] sram_addr,
  output logic              sram_cs,
  output logic              sram_we,
  output logic              sram_rd,
  input  logic [DATA_W-1:0] sram_q,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [2:0]        fail_elem,
  output logic [DATA_W-1:0] fail_data,
  output logic [DATA_W-1:0] fail_exp
);

  localparam logic [MAX_DATA_W-1:0] B0_FULL = bg_b0(DATA_W);
  localparam logic [MAX_DATA_W-1:0] B1_FULL = bg_b1(DATA_W);
  localparam logic [DATA_W-1:0]     B0      = B0_FULL[DATA_W-1:0];
  localparam logic [DATA_W-1:0]     B1      = B1_FULL[DATA_W-1:0];

  // WAIT lengths: before a write the compare lands in WR, so one cycle fewer
  localparam logic [1:0] WAIT_WR = (READ_LAT > 1) ? 2'(READ_LAT - 2) : 2'd0;
  localparam logic [1:0] WAIT_RO = 2'(READ_LAT - 1);

  bist_state_t       state, state_nxt;
  elem_idx_t         elem, elem_nxt, elem_inc;
  logic [1:0]        wcnt, wcnt_nxt;
  logic              ag_load, ag_down, ag_step, ag_last;
  logic [ADDR_W-1:0] ag_addr, ag_addr_nxt;
  logic [READ_LAT-1:0] rd_pipe;
  logic [READ_LAT:0]   pipe_ext;
  logic              cmp_now, mismatch, op_done, run_start, pass_flag;
  logic [DATA_W-1:0] exp_bg;

  sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .Clk      (Clk),
    .Rst      (Rst),
    .load     (ag_load),
    .down     (ag_down),
    .step     (ag_step),
    .addr     (ag_addr),
    .addr_nxt (ag_addr_nxt),
    .last     (ag_last)
  );

  // rd_pipe[READ_LAT-1] marks the cycle in which sram_q answers the read
  assign pipe_ext = {rd_pipe, sram_rd};
  assign cmp_now  = rd_pipe[READ_LAT-1];
  assign exp_bg   = MARCH_C[elem].rd_bg ? B1 : B0;
  assign mismatch = cmp_now && (sram_q != exp_bg);
  assign elem_inc = elem + 3'd1;

  always_comb begin
    state_nxt = state;
    elem_nxt  = elem;
    wcnt_nxt  = wcnt;
    ag_load   = 1'b0;
    ag_down   = 1'b0;
    ag_step   = 1'b0;
    op_done   = 1'b0;
    run_start = 1'b0;

    case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt = WR;
          elem_nxt  = '0;
          ag_load   = 1'b1;
          ag_down   = MARCH_C[0].down;
          run_start = 1'b1;
        end
      end
      WR: op_done = 1'b1;
      RD: begin
        if (MARCH_C[elem].has_wr && READ_LAT == 1) begin
          state_nxt = WR;
        end else begin
          state_nxt = WAIT;
          wcnt_nxt  = MARCH_C[elem].has_wr ? WAIT_WR : WAIT_RO;
        end
      end
      WAIT: begin
        if (wcnt == 2'd0) begin
          if (MARCH_C[elem].has_wr) state_nxt = WR;
          else                      op_done   = 1'b1;
        end else begin
          wcnt_nxt = wcnt - 2'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase

    // last op at this address is finished: step address, move to next element, or finish
    if (op_done) begin
      if (ag_last) begin
        if (elem == LAST_ELEM) begin
          state_nxt = DONE;
        end else begin
          elem_nxt  = elem_inc;
          ag_load   = 1'b1;
          ag_down   = MARCH_C[elem_inc].down;
          state_nxt = MARCH_C[elem_inc].has_rd ? RD : WR;
        end
      end else begin
        ag_step   = 1'b1;
        state_nxt = MARCH_C[elem].has_rd ? RD : WR;
      end
    end

`ifdef SRAM_BIST_DIAG_EN
    if (mismatch) begin
      state_nxt = DONE;
      elem_nxt  = elem;
      ag_load   = 1'b0;
      ag_step   = 1'b0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state     <= IDLE;
      elem      <= '0;
      wcnt      <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      pass_flag <= 1'b0;
      sram_cs   <= 1'b0;
      sram_we   <= 1'b0;
      sram_rd   <= 1'b0;
      sram_din  <= '0;
      sram_addr <= '0;
      rd_pipe   <= '0;
    end else begin
      state     <= state_nxt;
      elem      <= elem_nxt;
      wcnt      <= wcnt_nxt;
      busy      <= (state_nxt == WR) || (state_nxt == RD) || (state_nxt == WAIT);
      done      <= (state_nxt == DONE);
      sram_cs   <= (state_nxt == WR) || (state_nxt == RD);
      sram_we   <= (state_nxt == WR);
      sram_rd   <= (state_nxt == RD);
      sram_din  <= ((state_nxt == WR) && MARCH_C[elem_nxt].wr_bg) ? B1 : B0;
      sram_addr <= ((state_nxt == WR) || (state_nxt == RD)) ? ag_addr_nxt : '0;
      rd_pipe   <= pipe_ext[READ_LAT-1:0];

      if (run_start)     pass_flag <= 1'b1;
      else if (mismatch) pass_flag <= 1'b0;

      if (run_start) begin
        pass <= 1'b0;
      end else if ((state_nxt == DONE) && (state != DONE)) begin
        pass <= pass_flag && !mismatch;
      end
    end
  end

`ifdef SRAM_BIST_DIAG_EN
  // pass_flag still set means this is the first mismatch of the run
  always_ff @(posedge Clk) begin
    if (Rst || run_start) begin
      fail_addr <= '0;
      fail_elem <= '0;
      fail_data <= '0;
      fail_exp  <= '0;
    end else if (mismatch && pass_flag) begin
      fail_addr <= ag_addr;
      fail_elem <= elem;
      fail_data <= sram_q;
      fail_exp  <= exp_bg;
    end
  end
`else
  logic unused_ag_addr;
  assign unused_ag_addr = ^ag_addr;
  assign fail_addr = '0;
  assign fail_elem = '0;
  assign fail_data = '0;
  assign fail_exp  = '0;
`endif

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// Directed bench for sram_bist_ctrl: READ_LAT=1 instance with stuck-at fault injection,
// READ_LAT=2 instance with start held high; SRAM_BIST_DIAG_EN selects the expected fail reporting.
module tb_sram_bist_ctrl;

  logic       Clk;
  logic       Rst;
  logic       start, start_2;
  logic       busy, done, pass;
  logic       busy_2, done_2, pass_2;
  logic [3:0] sram_din, sram_din_2;
  logic [1:0] sram_addr, sram_addr_2;
  logic       sram_cs, sram_we, sram_rd;
  logic       sram_cs_2, sram_we_2, sram_rd_2;
  logic [3:0] sram_q, sram_q_2;
  logic [1:0] fail_addr, fail_addr_2;
  logic [2:0] fail_elem, fail_elem_2;
  logic [3:0] fail_data, fail_data_2, fail_exp, fail_exp_2;

  int checks = 0;
  int errors = 0;

  sram_bist_ctrl #(.ADDR_W(2), .DATA_W(4), .READ_LAT(1)) dut (
    .Clk(Clk), .Rst(Rst), .start(start), .busy(busy), .done(done), .pass(pass),
    .sram_din(sram_din), .sram_addr(sram_addr), .sram_cs(sram_cs), .sram_we(sram_we),
    .sram_rd(sram_rd), .sram_q(sram_q), .fail_addr(fail_addr), .fail_elem(fail_elem),
    .fail_data(fail_data), .fail_exp(fail_exp)
  );

  sram_bist_ctrl #(.ADDR_W(2), .DATA_W(4), .READ_LAT(2)) dut_2 (
    .Clk(Clk), .Rst(Rst), .start(start_2), .busy(busy_2), .done(done_2), .pass(pass_2),
    .sram_din(sram_din_2), .sram_addr(sram_addr_2), .sram_cs(sram_cs_2), .sram_we(sram_we_2),
    .sram_rd(sram_rd_2), .sram_q(sram_q_2), .fail_addr(fail_addr_2), .fail_elem(fail_elem_2),
    .fail_data(fail_data_2), .fail_exp(fail_exp_2)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // SRAM models: stuck-at masks apply on the read path
  logic [3:0] mem [4];
  logic [3:0] mem_2 [4];
  logic [3:0] sa1_m [4];
  logic [3:0] sa0_m [4];
  logic [3:0] p_2;

  always @(posedge Clk) begin
    if (sram_cs && sram_we) mem[sram_addr] <= sram_din;
    if (sram_cs && sram_rd) sram_q <= (mem[sram_addr] & ~sa0_m[sram_addr]) | sa1_m[sram_addr];
  end

  always @(posedge Clk) begin
    if (sram_cs_2 && sram_we_2) mem_2[sram_addr_2] <= sram_din_2;
    if (sram_cs_2 && sram_rd_2) p_2 <= mem_2[sram_addr_2];
    sram_q_2 <= p_2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // pin protocol on every cycle out of reset
  always @(negedge Clk) begin
    if (Rst === 1'b0) begin
      check("we_rd_excl", {31'd0, sram_we & sram_rd}, 32'd0);
      check("op_has_cs", {31'd0, (sram_we | sram_rd) & ~sram_cs}, 32'd0);
      check("we_rd_excl_2", {31'd0, sram_we_2 & sram_rd_2}, 32'd0);
      check("op_has_cs_2", {31'd0, (sram_we_2 | sram_rd_2) & ~sram_cs_2}, 32'd0);
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // pulse start, then count cycles with busy high; returns in the first cycle busy is low
  task automatic run_dut(output int n, input bit chk_pins);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    if (chk_pins) begin
      check("e0_first_we", sram_we, 1);
      check("e0_first_cs", sram_cs, 1);
      check("e0_first_addr", sram_addr, 0);
      check("e0_first_din", sram_din, 0);
    end
    n = 0;
    while (busy === 1'b1 && n < 200) begin
      if (chk_pins) begin
        if (n == 5) begin
          check("e1_wr_we", sram_we, 1);
          check("e1_wr_din", sram_din, 4'hF);
          check("e1_wr_addr", sram_addr, 0);
        end
        if (n == 22) begin
          check("e3_rd", sram_rd, 1);
          check("e3_down_addr", sram_addr, 2);
        end
        if (n == 42) begin
          check("e5_rd_addr", sram_addr, 3);
          check("e5_rd_we", sram_we, 0);
        end
        if (n == 43) begin
          check("e5_cmp_cs", sram_cs, 0);
          check("e5_cmp_addr", sram_addr, 0);
        end
      end
      n++;
      tick();
    end
  endtask

  initial begin
    int n;
    Rst = 1'b1;
    start = 1'b0;
    start_2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sa1_m[i] = 4'h0;
      sa0_m[i] = 4'h0;
    end
    repeat (3) tick();

    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_cs", sram_cs, 0);
    check("rst_we", sram_we, 0);
    check("rst_rd", sram_rd, 0);
    check("rst_din", sram_din, 0);
    check("rst_addr", sram_addr, 0);
    check("rst_fail_addr", fail_addr, 0);
    check("rst_fail_elem", fail_elem, 0);
    check("rst_fail_data", fail_data, 0);
    check("rst_fail_exp", fail_exp, 0);
    check("rst_busy_2", busy_2, 0);
    check("rst_done_2", done_2, 0);

    Rst = 1'b0;
    tick();

    // fault-free run with pin spot checks
    run_dut(n, 1'b1);
    check("clean_len", n, 44);
    check("clean_done", done, 1);
    check("clean_pass", pass, 1);
    check("clean_fail_addr", fail_addr, 0);
    repeat (3) tick();
    check("done_hold", done, 1);
    check("pass_hold", pass, 1);
    check("idle_busy", busy, 0);
    check("idle_cs", sram_cs, 0);

    // reset in cycle 10 of a run
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    check("mid_busy", busy, 1);
    Rst = 1'b1;
    tick();
    check("abort_cs", sram_cs, 0);
    check("abort_we", sram_we, 0);
    check("abort_rd", sram_rd, 0);
    check("abort_din", sram_din, 0);
    check("abort_addr", sram_addr, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    Rst = 1'b0;
    tick();
    run_dut(n, 1'b0);
    check("rerun_len", n, 44);
    check("rerun_pass", pass, 1);

    // address 2 bit 0 stuck-at-1: caught by the first read of address 2 in E1
    sa1_m[2] = 4'b0001;
    run_dut(n, 1'b0);
    check("sa1_done", done, 1);
    check("sa1_pass", pass, 0);
`ifdef SRAM_BIST_DIAG_EN
    check("sa1_len", n, 10);
    check("sa1_fail_addr", fail_addr, 2);
    check("sa1_fail_elem", fail_elem, 1);
    check("sa1_fail_data", fail_data, 4'b0001);
    check("sa1_fail_exp", fail_exp, 4'b0000);
`else
    check("sa1_len", n, 44);
    check("sa1_fail_addr", fail_addr, 0);
    check("sa1_fail_elem", fail_elem, 0);
    check("sa1_fail_data", fail_data, 0);
    check("sa1_fail_exp", fail_exp, 0);
`endif
    sa1_m[2] = 4'h0;

    // address 3 bit 3 stuck-at-0: first seen when E2 reads B1 at address 3
    sa0_m[3] = 4'b1000;
    run_dut(n, 1'b0);
    check("sa0_done", done, 1);
    check("sa0_pass", pass, 0);
`ifdef SRAM_BIST_DIAG_EN
    check("sa0_len", n, 20);
    check("sa0_fail_addr", fail_addr, 3);
    check("sa0_fail_elem", fail_elem, 2);
    check("sa0_fail_data", fail_data, 4'b0111);
    check("sa0_fail_exp", fail_exp, 4'b1111);
`else
    check("sa0_len", n, 44);
    check("sa0_fail_addr", fail_addr, 0);
`endif
    sa0_m[3] = 4'h0;

    // clean again: pass restored and capture registers cleared by start
    run_dut(n, 1'b0);
    check("post_len", n, 44);
    check("post_pass", pass, 1);
    check("post_fail_addr", fail_addr, 0);
    check("post_fail_data", fail_data, 0);

    // READ_LAT=2 with start held high: back-to-back runs
    start_2 = 1'b1;
    tick();
    check("rl2_busy", busy_2, 1);
    n = 0;
    while (busy_2 === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("rl2_len1", n, 64);
    check("rl2_done1", done_2, 1);
    check("rl2_pass1", pass_2, 1);
    tick();
    check("rl2_done_pulse", done_2, 0);
    check("rl2_restart", busy_2, 1);
    n = 0;
    while (busy_2 === 1'b1 && n < 200) begin
      n++;
      tick();
    end
    check("rl2_len2", n, 64);
    check("rl2_done2", done_2, 1);
    start_2 = 1'b0;
    tick();
    check("rl2_done_hold", done_2, 1);
    check("rl2_pass_hold", pass_2, 1);
    check("rl2_idle", busy_2, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
